// File: rtl/pal_macrocell_array.sv
// pal_macrocell_array
//   Parametrised PAL: AND plane -> OR plane -> per-output macrocell.
//   The whole fabric is programmed via a serial shift chain loaded under
//   control of a small load FSM. Outputs stay at 0 until a complete
//   bitstream has been shifted in.
//
//   Ports:
//     clk, rst_n     single clock, synchronous active-low reset
//     cfg_start      begin (re)load of the bitstream
//     cfg_valid      cfg_data carries a bit this cycle
//     cfg_data       serial configuration bit
//     cfg_busy       load in progress
//     cfg_done       full bitstream loaded
//     cfg_dout       readback of chain[0] (only with PAL_READBACK_EN)
//     enable         output enable (also freezes registered macrocells)
//     in_data        logic inputs
//     out_data       logic outputs
//
//   Build option: define PAL_READBACK_EN to expose chain[0] on cfg_dout;
//   otherwise cfg_dout is tied low.
//
//   Chain map (bit 0 is the first bit sent):
//     [t*2*NUM_INPUTS + 2i]      term t uses  in_data[i]
//     [t*2*NUM_INPUTS + 2i + 1]  term t uses ~in_data[i]
//     [AND_LEN + o*NUM_TERMS + t]   output o includes term t
//     [AND_LEN + OR_LEN + 2o]       macrocell o reg_sel
//     [AND_LEN + OR_LEN + 2o + 1]   macrocell o invert

// One output macrocell: polarity control plus an optional output flop.
module pal_macrocell (
    input  logic clk,
    input  logic rst_n,
    input  logic done,     // bitstream fully loaded
    input  logic run,      // done & enable
    input  logic or_in,
    input  logic reg_sel,
    input  logic invert,
    output logic out
);
    logic f;
    logic q_d, q_q;

    always_comb begin
        f   = or_in ^ invert;
        q_d = q_q;
        if (!done) begin
            q_d = 1'b0;
        end else if (run) begin
            q_d = f;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign out = run ? (reg_sel ? q_q : f) : 1'b0;
endmodule

module pal_macrocell_array #(
    parameter int NUM_INPUTS  = 8,
    parameter int NUM_OUTPUTS = 4,
    parameter int NUM_TERMS   = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_start,
    input  logic                   cfg_valid,
    input  logic                   cfg_data,
    output logic                   cfg_busy,
    output logic                   cfg_done,
    output logic                   cfg_dout,
    input  logic                   enable,
    input  logic [NUM_INPUTS-1:0]  in_data,
    output logic [NUM_OUTPUTS-1:0] out_data
);
    localparam int LIT_W   = 2 * NUM_INPUTS;
    localparam int AND_LEN = LIT_W * NUM_TERMS;
    localparam int OR_LEN  = NUM_TERMS * NUM_OUTPUTS;
    localparam int MC_BASE = AND_LEN + OR_LEN;
    localparam int CFG_LEN = AND_LEN + OR_LEN + 2 * NUM_OUTPUTS;
    localparam int CW      = $clog2(CFG_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_t;

    // Field order matches chain order: reg_sel is the lower bit.
    typedef struct packed {
        logic invert;
        logic reg_sel;
    } mc_cfg_t;

    state_t              state_d, state_q;
    logic [CW-1:0]       cnt_d, cnt_q;
    logic [CFG_LEN-1:0]  chain_d, chain_q;

    // ---------------- load FSM / shift chain ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        chain_d = chain_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                // A restart wins over a data bit in the same cycle.
                if (cfg_start) begin
                    cnt_d = '0;
                end else if (cfg_valid) begin
                    chain_d = {cfg_data, chain_q[CFG_LEN-1:1]};
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(CFG_LEN - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (cfg_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Configuration contents survive reset; only a full load validates them.
    always_ff @(posedge clk) begin
        chain_q <= chain_d;
    end

    logic done, run;
    assign done     = (state_q == ST_DONE);
    assign run      = done & enable;
    assign cfg_busy = (state_q == ST_LOAD);
    assign cfg_done = done;

`ifdef PAL_READBACK_EN
    assign cfg_dout = chain_q[0];
`else
    assign cfg_dout = 1'b0;
`endif

    // ---------------- AND plane ----------------
    // A term with no literal selected evaluates to 0, not to a tautology.
    logic [NUM_TERMS-1:0] term;

    for (genvar t = 0; t < NUM_TERMS; t++) begin : g_term
        logic [LIT_W-1:0]      lit;
        logic [NUM_INPUTS-1:0] lit_ok;
        assign lit = chain_q[t*LIT_W +: LIT_W];
        for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lit
            assign lit_ok[i] = (~lit[2*i] | in_data[i]) & (~lit[2*i+1] | ~in_data[i]);
        end
        assign term[t] = (|lit) & (&lit_ok);
    end

    // ---------------- OR plane + macrocells ----------------
    logic    [NUM_OUTPUTS-1:0][NUM_TERMS-1:0] or_sel;
    logic    [NUM_OUTPUTS-1:0]                or_out;
    mc_cfg_t [NUM_OUTPUTS-1:0]                mc_cfg;

    for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_out
        assign or_sel[o] = chain_q[AND_LEN + o*NUM_TERMS +: NUM_TERMS];
        assign or_out[o] = |(term & or_sel[o]);
        assign mc_cfg[o] = mc_cfg_t'(chain_q[MC_BASE + 2*o +: 2]);

        pal_macrocell u_mc (
            .clk     (clk),
            .rst_n   (rst_n),
            .done    (done),
            .run     (run),
            .or_in   (or_out[o]),
            .reg_sel (mc_cfg[o].reg_sel),
            .invert  (mc_cfg[o].invert),
            .out     (out_data[o])
        );
    end
endmodule

// File: tb/tb_pal_macrocell_array.sv
// Bench for pal_macrocell_array (8 inputs, 4 outputs, 14 terms, 288-bit chain).
// A behavioural model keeps the full history of shifted bits and evaluates
// the sum-of-products directly from it; a negedge process compares against
// it every cycle, and directed steps pin a few hand-computed values.
module tb_pal_macrocell_array;
    localparam int NI      = 8;
    localparam int NO      = 4;
    localparam int NT      = 14;
    localparam int AND_LEN = 2 * NI * NT;
    localparam int OR_LEN  = NT * NO;
    localparam int MC_BASE = AND_LEN + OR_LEN;
    localparam int CFG_LEN = MC_BASE + 2 * NO;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_data = 1'b0;
    logic          cfg_busy, cfg_done, cfg_dout;
    logic          enable = 1'b0;
    logic [NI-1:0] in_data = '0;
    logic [NO-1:0] out_data;

    int checks = 0;
    int failures = 0;

    pal_macrocell_array #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .NUM_TERMS(NT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_dout  (cfg_dout),
        .enable    (enable),
        .in_data   (in_data),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    // m_state: 0 idle, 1 loading, 2 loaded
    bit      hist[$];
    int      m_state = 0;
    int      m_cnt = 0;
    bit      m_q[NO];
    bit      chk_en = 1'b0;

    // Chain bit k = the bit shifted in CFG_LEN-k shifts ago.
    function automatic bit cbit(int k);
        if (hist.size() < CFG_LEN) return 1'b0;
        return hist[hist.size() - CFG_LEN + k];
    endfunction

    function automatic bit f_of(int o, logic [NI-1:0] x);
        bit any_term = 1'b0;
        for (int t = 0; t < NT; t++) begin
            if (cbit(AND_LEN + o*NT + t)) begin
                bit used = 1'b0;
                bit ok = 1'b1;
                for (int i = 0; i < NI; i++) begin
                    if (cbit(t*2*NI + 2*i))     begin used = 1'b1; if (!x[i]) ok = 1'b0; end
                    if (cbit(t*2*NI + 2*i + 1)) begin used = 1'b1; if (x[i])  ok = 1'b0; end
                end
                if (used && ok) any_term = 1'b1;
            end
        end
        return any_term ^ cbit(MC_BASE + 2*o + 1);
    endfunction

    function automatic logic [NO-1:0] exp_out(logic [NI-1:0] x, logic en);
        logic [NO-1:0] r = '0;
        if (m_state == 2 && en) begin
            for (int o = 0; o < NO; o++)
                r[o] = cbit(MC_BASE + 2*o) ? m_q[o] : f_of(o, x);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_state = 0;
            m_cnt   = 0;
            for (int o = 0; o < NO; o++) m_q[o] = 1'b0;
        end else begin
            for (int o = 0; o < NO; o++) begin
                if (m_state == 2) begin
                    if (enable) m_q[o] = f_of(o, in_data);
                end else begin
                    m_q[o] = 1'b0;
                end
            end
            case (m_state)
                0: if (cfg_start) begin m_state = 1; m_cnt = 0; end
                1: begin
                    if (cfg_start) m_cnt = 0;
                    else if (cfg_valid) begin
                        hist.push_back(cfg_data);
                        if (m_cnt == CFG_LEN - 1) m_state = 2;
                        m_cnt++;
                    end
                end
                default: if (cfg_start) begin m_state = 1; m_cnt = 0; end
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_data", 32'(out_data), 32'(exp_out(in_data, enable)));
            chk("cfg_busy", 32'(cfg_busy), 32'(m_state == 1));
            chk("cfg_done", 32'(cfg_done), 32'(m_state == 2));
`ifdef PAL_READBACK_EN
            if (hist.size() >= CFG_LEN) chk("cfg_dout", 32'(cfg_dout), 32'(cbit(0)));
`else
            chk("cfg_dout", 32'(cfg_dout), 32'd0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [CFG_LEN-1:0] p);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b1;
        for (int k = 0; k < CFG_LEN; k++) begin
            cfg_data = p[k];
            tick();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic shift_bits(input int n);
        cfg_valid = 1'b1;
        for (int k = 0; k < n; k++) begin
            cfg_data = k[0];
            tick();
        end
        cfg_valid = 1'b0;
    endtask

    logic [CFG_LEN-1:0] p2, p4, pb;

    initial begin
        p2 = '0;
        p2[1] = 1'b1; p2[18] = 1'b1; p2[21] = 1'b1; p2[224] = 1'b1; p2[225] = 1'b1;
        p4 = p2;
        p4[280] = 1'b1; p4[283] = 1'b1;
        for (int k = 0; k < CFG_LEN; k++) pb[k] = 1'($urandom_range(0, 1));

        // 1: reset and ignored cfg_valid in IDLE
        tick(); tick();
        chk("rst_out", 32'(out_data), 32'h0);
        chk("rst_busy", 32'(cfg_busy), 32'h0);
        chk("rst_done", 32'(cfg_done), 32'h0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        enable = 1'b1;
        cfg_valid = 1'b1; cfg_data = 1'b1;
        tick(); tick(); tick();
        cfg_valid = 1'b0;
        chk("idle_busy", 32'(cfg_busy), 32'h0);
        chk("idle_done", 32'(cfg_done), 32'h0);
        chk("idle_out", 32'(out_data), 32'h0);

        // 2: O0 = ~I0 | (I1 & ~I2)
        load(p2);
        chk("p2_done", 32'(cfg_done), 32'h1);
        chk("p2_busy", 32'(cfg_busy), 32'h0);
        in_data = 8'h00; #1; chk("p2_in00", 32'(out_data), 32'h1);
        tick(); in_data = 8'h03; #1; chk("p2_in03", 32'(out_data), 32'h1);
        tick(); in_data = 8'h07; #1; chk("p2_in07", 32'(out_data), 32'h0);
        tick(); in_data = 8'hF7; #1; chk("p2_inF7", 32'(out_data), 32'h0);

        // 3: output gating acts in the same cycle
        tick(); in_data = 8'h00; enable = 1'b0; #1; chk("gate_off", 32'(out_data), 32'h0);
        tick(); enable = 1'b1; #1; chk("gate_on", 32'(out_data), 32'h1);
        tick();

        // 4: O0 registered, O1 inverted empty OR
        load(p4);
        in_data = 8'h07; #1; chk("mc_init", 32'(out_data), 32'h2);
        tick(); in_data = 8'h00; #1; chk("mc_hold", 32'(out_data), 32'h2);
        tick(); chk("mc_reg1", 32'(out_data), 32'h3);
        enable = 1'b0; #1; chk("mc_gate", 32'(out_data), 32'h0);
        in_data = 8'h07;
        tick(); tick();
        enable = 1'b1; #1; chk("mc_frozen", 32'(out_data), 32'h3);
        tick(); chk("mc_reg0", 32'(out_data), 32'h2);

        // 5: restart mid-load, restart from DONE, reset mid-load
        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        shift_bits(100);
        cfg_start = 1'b1; cfg_valid = 1'b1; tick(); cfg_start = 1'b0; cfg_valid = 1'b0;
        cfg_valid = 1'b1;
        for (int k = 0; k < CFG_LEN - 1; k++) begin cfg_data = p2[k]; tick(); end
        cfg_valid = 1'b0;
        chk("restart_notdone", 32'(cfg_done), 32'h0);
        chk("restart_busy", 32'(cfg_busy), 32'h1);
        cfg_valid = 1'b1; cfg_data = p2[CFG_LEN-1]; tick(); cfg_valid = 1'b0;
        chk("restart_done", 32'(cfg_done), 32'h1);
        in_data = 8'h00; #1; chk("restart_out", 32'(out_data), 32'h1);
        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        chk("reld_out", 32'(out_data), 32'h0);
        chk("reld_busy", 32'(cfg_busy), 32'h1);
        chk("reld_done", 32'(cfg_done), 32'h0);
        shift_bits(50);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("mrst_busy", 32'(cfg_busy), 32'h0);
        chk("mrst_done", 32'(cfg_done), 32'h0);
        tick();

        // 6: readback streams the previous bitstream out, bit 0 first
        load(p4);
        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        cfg_valid = 1'b1;
        for (int k = 0; k < CFG_LEN; k++) begin
            cfg_data = pb[k];
`ifdef PAL_READBACK_EN
            chk("readback", 32'(cfg_dout), 32'(p4[k]));
`else
            chk("dout_tied", 32'(cfg_dout), 32'h0);
`endif
            tick();
        end
        cfg_valid = 1'b0;
        chk("b_done", 32'(cfg_done), 32'h1);
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
